// File: rtl/stopwatch_pkg.sv
// Purpose : shared types and constants for the stopwatch controller.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encoding, BCD digit width and limits, packed mm:ss
//           time struct, and a carry-chained BCD increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int BCD_W = 4;
  // Units digits (seconds and minutes) wrap after 9, tens digits after 5.
  localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  // One-second increment. Each digit is compared against its limit and
  // cleared rather than added modulo, so an out-of-range digit can never
  // be produced. 59:59 rolls over to 00:00 silently.
  function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones == SEC_ONES_MAX) begin
      r.sec_ones = '0;
      if (t.sec_tens == SEC_TENS_MAX) begin
        r.sec_tens = '0;
        if (t.min_ones == SEC_ONES_MAX) begin
          r.min_ones = '0;
          if (t.min_tens == SEC_TENS_MAX) begin
            r.min_tens = '0;
          end else begin
            r.min_tens = t.min_tens + 4'd1;
          end
        end else begin
          r.min_ones = t.min_ones + 4'd1;
        end
      end else begin
        r.sec_tens = t.sec_tens + 4'd1;
      end
    end else begin
      r.sec_ones = t.sec_ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Purpose : divides clk into a one-cycle enable tick every DIV cycles.
// Latency : tick is combinational from the counter; first tick DIV-1 cycles after en rises from a cleared count.
// Backpressure: none; en low freezes the count, clr forces it to 0 (clr wins).
// Ports   : clk, rst_n (async active-low), en (count enable), clr (sync
//           clear), tick (high while enabled and count == DIV-1).
module tick_prescaler #(
  parameter int DIV   = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose : stopwatch FSM (IDLE/RUN/PAUSE/LAP) driving a 1 Hz prescaler and a BCD mm:ss counter with lap freeze.
// Latency : digits, running and lap_active are registered; digits change on the edge where tick is high.
// Backpressure: none; button pulses are consumed on the edge they are sampled, start_stop beats lap_reset.
// Ports   : clk, rst_n, start_stop/lap_reset (debounced one-cycle pulses),
//           tick (1 s enable), running, lap_active, BCD digits mm:ss.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV   = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             lap_reset,
  output logic             tick,
  output logic             running,
  output logic             lap_active,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens
);

  sw_state_e state_q, state_d;
  bcd_time_t live_q, live_d;
  bcd_time_t lap_q, lap_d;
  bcd_time_t disp_q, disp_d;
  logic      running_q, running_d;
  logic      lap_act_q, lap_act_d;
  logic      clear_live;
  logic      pre_en;
  logic      pre_clr;

  // Enable follows the current state, so a tick coinciding with a stop
  // pulse is still counted.
  assign pre_en  = (state_q == RUN) || (state_q == LAP);
  // Clearing on the next state both zeroes the count on PAUSE->IDLE and
  // pins it at zero for as long as the FSM sits in IDLE.
  assign pre_clr = (state_d == IDLE);

  tick_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    lap_d      = lap_q;
    clear_live = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap_reset) begin
          state_d = LAP;
          // Captures the pre-increment value even if tick fires this cycle.
          lap_d   = live_q;
        end
      end
      LAP: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap_reset) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_reset) begin
          state_d    = IDLE;
          clear_live = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    live_d = live_q;
    if (clear_live) begin
      live_d = '0;
    end else if (tick) begin
      live_d = bcd_time_inc(live_q);
    end

    // Display is driven from next-state values so it moves on the same
    // edge as the live time and the state change.
    disp_d    = (state_d == LAP) ? lap_d : live_d;
    running_d = (state_d == RUN) || (state_d == LAP);
    lap_act_d = (state_d == LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= '0;
      lap_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      lap_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      lap_act_q <= lap_act_d;
    end
  end

  assign running    = running_q;
  assign lap_active = lap_act_q;
  assign sec_ones   = disp_q.sec_ones;
  assign sec_tens   = disp_q.sec_tens;
  assign min_ones   = disp_q.min_ones;
  assign min_tens   = disp_q.min_tens;

endmodule
